fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 71 +++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : four-state instruction fetcher with PC redirect and handshake
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [15:0] mem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        en_pc,
    input  logic        pc_mux_en,
    input  logic [15:0] branch_target,
    output logic [15:0] pc,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0] state;
    logic       redirect;

    assign redirect  = en_pc & pc_mux_en;
    assign mem_addr  = pc;
    assign mem_rd_en = (state == S_REQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            fetch_count <= 16'h0000;
        end else if (redirect) begin
            // Redirect beats everything, including an in-flight read or an accept
            pc          <= branch_target;
            instr_valid <= 1'b0;
            state       <= S_REQ;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ:  state <= S_WAIT;
                S_WAIT: begin
                    instr       <= mem_data;
                    instr_valid <= 1'b1;
                    state       <= S_HOLD;
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        pc          <= pc + 16'd1;
                        fetch_count <= fetch_count + 16'd1;
                        instr_valid <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        en_pc;
    logic        pc_mux_en;
    logic [15:0] branch_target;
    logic [15:0] pc;
    logic [15:0] fetch_count;

    int n_tests;
    int n_fail;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_data     (mem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .en_pc        (en_pc),
        .pc_mux_en    (pc_mux_en),
        .branch_target(branch_target),
        .pc           (pc),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ram_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h0512;
        return (a * 16'h0101) ^ 16'h3C00;
    endfunction

    // Synchronous RAM: data appears the cycle after the strobe is sampled
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= ram_word(mem_addr);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},    pc,                 16'h0000);
        check({tag, "_addr"},  mem_addr,           16'h0000);
        check({tag, "_rd"},    {15'd0, mem_rd_en}, 16'd0);
        check({tag, "_instr"}, instr,              16'h0000);
        check({tag, "_valid"}, {15'd0, instr_valid}, 16'd0);
        check({tag, "_cnt"},   fetch_count,        16'h0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b0;
        instr_ready   = 1'b0;
        en_pc         = 1'b0;
        pc_mux_en     = 1'b0;
        branch_target = 16'h0000;
        mem_data      = 16'h0000;

        step();
        step();
        check_reset_values("rst");

        // First fetch with decoder always ready
        reset       = 1'b1;
        instr_ready = 1'b1;
        step();
        check("c2_rd",    {15'd0, mem_rd_en},   16'd1);
        check("c2_valid", {15'd0, instr_valid}, 16'd0);
        step();
        check("c3_rd",    {15'd0, mem_rd_en},   16'd0);
        check("c3_valid", {15'd0, instr_valid}, 16'd0);
        step();
        check("c4_valid", {15'd0, instr_valid}, 16'd1);
        check("c4_instr", instr, 16'h0512);
        check("c4_pc",    pc,    16'h0000);
        step();
        check("acc_pc",    pc,          16'h0001);
        check("acc_cnt",   fetch_count, 16'h0001);
        check("acc_valid", {15'd0, instr_valid}, 16'd0);
        check("acc_addr",  mem_addr,    16'h0001);

        // Decoder stalls for 10 cycles in HOLD
        instr_ready = 1'b0;
        step();
        step();
        check("hold_valid0", {15'd0, instr_valid}, 16'd1);
        check("hold_instr0", instr, ram_word(16'h0001));
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_valid", {15'd0, instr_valid}, 16'd1);
            check("stall_instr", instr, ram_word(16'h0001));
            check("stall_rd",    {15'd0, mem_rd_en}, 16'd0);
            check("stall_pc",    pc, 16'h0001);
        end

        // en_pc without pc_mux_en is a no-op
        en_pc         = 1'b1;
        branch_target = 16'h1234;
        step();
        check("nomux_pc",    pc, 16'h0001);
        check("nomux_valid", {15'd0, instr_valid}, 16'd1);
        en_pc = 1'b0;

        instr_ready = 1'b1;
        step();
        check("acc2_pc",  pc,          16'h0002);
        check("acc2_cnt", fetch_count, 16'h0002);
        instr_ready = 1'b0;

        // Redirect while the read for pc=2 is in flight
        step();
        en_pc         = 1'b1;
        pc_mux_en     = 1'b1;
        branch_target = 16'h0040;
        step();
        en_pc     = 1'b0;
        pc_mux_en = 1'b0;
        check("rdw_pc",    pc,       16'h0040);
        check("rdw_addr",  mem_addr, 16'h0040);
        check("rdw_rd",    {15'd0, mem_rd_en},   16'd1);
        check("rdw_valid", {15'd0, instr_valid}, 16'd0);
        check("rdw_instr", instr,    ram_word(16'h0001));
        check("rdw_cnt",   fetch_count, 16'h0002);
        step();
        check("rdw_wait_valid", {15'd0, instr_valid}, 16'd0);
        step();
        check("rdw_hold_valid", {15'd0, instr_valid}, 16'd1);
        check("rdw_hold_instr", instr, ram_word(16'h0040));

        // Redirect and accept together: redirect wins
        en_pc         = 1'b1;
        pc_mux_en     = 1'b1;
        branch_target = 16'hFFFF;
        instr_ready   = 1'b1;
        step();
        en_pc     = 1'b0;
        pc_mux_en = 1'b0;
        check("both_pc",    pc,          16'hFFFF);
        check("both_cnt",   fetch_count, 16'h0002);
        check("both_valid", {15'd0, instr_valid}, 16'd0);

        // Fetch at 0xFFFF and accept: pc wraps
        step();
        step();
        check("ff_instr", instr, ram_word(16'hFFFF));
        step();
        check("wrap_pc",   pc,          16'h0000);
        check("wrap_addr", mem_addr,    16'h0000);
        check("wrap_cnt",  fetch_count, 16'h0003);
        instr_ready = 1'b0;

        // Asynchronous reset during HOLD
        step();
        step();
        check("pre_rst_valid", {15'd0, instr_valid}, 16'd1);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values("arst");

        step();
        reset = 1'b1;
        step();
        check("rel_c2_rd",    {15'd0, mem_rd_en},   16'd1);
        check("rel_c2_valid", {15'd0, instr_valid}, 16'd0);
        step();
        check("rel_c3_valid", {15'd0, instr_valid}, 16'd0);
        step();
        check("rel_c4_valid", {15'd0, instr_valid}, 16'd1);
        check("rel_c4_instr", instr, 16'h0512);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
